chirp_sequencer: RTL and testbench

Programmable chirp generator and controller. Sweeps a square-wave output from a slow start half-period down to a fast end half-period in fixed steps. Each frequency step is held for a configured number of full periods. Software or a test controller starts, aborts and monitors the sweep through a start/busy/done handshake; it sits alongside chirpcounter-class blocks as their sequencing front end.

---
 rtl/chirp_sequencer_pkg.sv | 13 +
 rtl/chirp_sequencer_if.sv | 30 +++
 rtl/chirp_halfperiod_timer.sv | 30 +++
 rtl/chirp_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_chirp_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/chirp_sequencer_pkg.sv
// Shared definitions for the chirp sequencer: state encoding and default widths.
package chirp_sequencer_pkg;

    localparam int DIV_W_DEF = 8;
    localparam int REP_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chirp_sequencer_if.sv
// Control/status bundle between a sweep controller (master) and the sequencer (slave).
interface chirp_sequencer_if import chirp_sequencer_pkg::*; #(
    parameter int DIV_W = DIV_W_DEF,
    parameter int REP_W = REP_W_DEF
) ();

    logic             start;
    logic             abort;
    logic [DIV_W-1:0] cfg_start_div;
    logic [DIV_W-1:0] cfg_end_div;
    logic [DIV_W-1:0] cfg_step;
    logic [REP_W-1:0] cfg_reps;
    logic             cfg_loop;
    logic             out;
    logic             busy;
    logic             done;
    logic             err;
    logic [DIV_W-1:0] cur_div;

    modport master (
        output start, abort, cfg_start_div, cfg_end_div, cfg_step, cfg_reps, cfg_loop,
        input  out, busy, done, err, cur_div
    );

    modport slave (
        input  start, abort, cfg_start_div, cfg_end_div, cfg_step, cfg_reps, cfg_loop,
        output out, busy, done, err, cur_div
    );

endinterface

// File: rtl/chirp_halfperiod_timer.sv
// Half-period timer: counts clk cycles and ticks on the last cycle of each half-period.
module chirp_halfperiod_timer import chirp_sequencer_pkg::*; #(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             asyn_rst,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_count;

    // Tick on count==div-1 so a half-period spans exactly div cycles.
    assign o_tick = i_en && (r_count == i_div - DIV_W'(1));

    // Counter clears on load, wraps to zero on tick, otherwise advances while enabled.
    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            if (o_tick) r_count <= '0;
            else        r_count <= r_count + DIV_W'(1);
        end
    end

endmodule

// File: rtl/chirp_sequencer.sv
// Chirp sequencer: sweeps a square wave from a slow to a fast half-period in
// saturating steps, holding each step for a configured number of full periods.
module chirp_sequencer import chirp_sequencer_pkg::*; #(
    parameter int DIV_W = DIV_W_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic        clk,
    input  logic        asyn_rst,
    chirp_sequencer_if.slave bus
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [DIV_W-1:0] r_start_div;
    logic [DIV_W-1:0] r_end_div;
    logic [DIV_W-1:0] r_step;
    logic [REP_W-1:0] r_reps;
    logic             r_loop;
    logic [REP_W-1:0] r_rep_cnt;

    logic             r_out;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic [DIV_W-1:0] r_cur_div;

    logic             w_out_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic [DIV_W-1:0] w_cur_div_nxt;

    logic             w_tick;
    logic             w_cfg_valid;
    logic             w_accept;
    logic             w_period_end;
    logic             w_step_end;
    logic             w_sweep_end;
    logic             w_timer_load;
    logic             w_timer_en;

    function automatic logic cfg_valid(
        input logic [DIV_W-1:0] sd,
        input logic [DIV_W-1:0] ed,
        input logic [DIV_W-1:0] st,
        input logic [REP_W-1:0] rp
    );
        return (ed != '0) && (sd >= ed) && (st != '0) && (rp != '0);
    endfunction

    // Next half-period, clamped at end_div; cur >= end always holds in RUN.
    function automatic logic [DIV_W-1:0] sat_step(
        input logic [DIV_W-1:0] cur,
        input logic [DIV_W-1:0] ed,
        input logic [DIV_W-1:0] st
    );
        return ((cur - ed) > st) ? (cur - st) : ed;
    endfunction

    assign w_cfg_valid  = cfg_valid(bus.cfg_start_div, bus.cfg_end_div, bus.cfg_step, bus.cfg_reps);
    assign w_accept     = (r_state == ST_IDLE) && bus.start && !bus.abort && w_cfg_valid;
    assign w_period_end = w_tick && r_out;
    assign w_step_end   = w_period_end && (r_rep_cnt == r_reps - REP_W'(1));
    assign w_sweep_end  = w_step_end && (r_cur_div == r_end_div);
    assign w_timer_en   = (r_state == ST_RUN);
    assign w_timer_load = (r_state != ST_RUN);

    chirp_halfperiod_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (clk),
        .asyn_rst (asyn_rst),
        .i_load   (w_timer_load),
        .i_en     (w_timer_en),
        .i_div    (r_cur_div),
        .o_tick   (w_tick)
    );

    // State register.
    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; abort outranks start in IDLE and sweep end in RUN.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (bus.abort)                     w_state_nxt = ST_IDLE;
                else if (w_sweep_end && !r_loop)   w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        w_out_nxt     = 1'b0;
        w_busy_nxt    = 1'b0;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
        w_cur_div_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_busy_nxt    = 1'b1;
                    w_cur_div_nxt = bus.cfg_start_div;
                end else if (bus.start && !bus.abort) begin
                    w_err_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_busy_nxt = 1'b0;
                end else if (w_sweep_end && !r_loop) begin
                    w_done_nxt = 1'b1;
                end else begin
                    w_busy_nxt    = 1'b1;
                    w_out_nxt     = w_tick ? ~r_out : r_out;
                    w_cur_div_nxt = r_cur_div;
                    if (w_sweep_end)     w_cur_div_nxt = r_start_div;
                    else if (w_step_end) w_cur_div_nxt = sat_step(r_cur_div, r_end_div, r_step);
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            r_out     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cur_div <= '0;
        end else begin
            r_out     <= w_out_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_cur_div <= w_cur_div_nxt;
        end
    end

    // Configuration is captured only on the accepting start cycle.
    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            r_start_div <= '0;
            r_end_div   <= '0;
            r_step      <= '0;
            r_reps      <= '0;
            r_loop      <= 1'b0;
        end else if (w_accept) begin
            r_start_div <= bus.cfg_start_div;
            r_end_div   <= bus.cfg_end_div;
            r_step      <= bus.cfg_step;
            r_reps      <= bus.cfg_reps;
            r_loop      <= bus.cfg_loop;
        end
    end

    // Full-period repeat counter; wraps to zero at each step end.
    always_ff @(posedge clk or posedge asyn_rst) begin
        if (asyn_rst) begin
            r_rep_cnt <= '0;
        end else if (r_state != ST_RUN) begin
            r_rep_cnt <= '0;
        end else if (w_period_end) begin
            r_rep_cnt <= w_step_end ? '0 : r_rep_cnt + REP_W'(1);
        end
    end

    assign bus.out     = r_out;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
    assign bus.cur_div = r_cur_div;

endmodule

// File: tb/tb_chirp_sequencer.sv
// Self-checking bench for chirp_sequencer: vector table, hand sequences, random configs.
module tb_chirp_sequencer;

    logic clk = 1'b0;
    logic asyn_rst = 1'b1;

    chirp_sequencer_if #(.DIV_W(8), .REP_W(4)) bus ();

    chirp_sequencer #(.DIV_W(8), .REP_W(4)) dut (
        .clk      (clk),
        .asyn_rst (asyn_rst),
        .bus      (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] sd;
        logic [7:0] ed;
        logic [7:0] st;
        logic [3:0] rp;
        logic       exp_err;
        int         exp_busy;
    } vec_t;

    vec_t       tbl[8];
    logic [9:0] mq[$];   // expected {busy,out,cur_div} per RUN cycle
    int         n_vec = 0;
    int         n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] obs();
        return {bus.busy, bus.out, bus.cur_div};
    endfunction

    function automatic logic model_valid(input int sd, input int ed, input int st, input int rp);
        return (ed >= 1) && (sd >= ed) && (st >= 1) && (rp >= 1);
    endfunction

    // Expected sweep: list of half-periods, each step held for rp full periods.
    task automatic build_model(input int sd, input int ed, input int st, input int rp);
        int d;
        mq.delete();
        d = sd;
        while (1) begin
            for (int r = 0; r < rp; r++)
                for (int h = 0; h < 2; h++)
                    for (int c = 0; c < d; c++)
                        mq.push_back({1'b1, (h == 1), 8'(d)});
            if (d == ed) break;
            d = (d - st < ed) ? ed : d - st;
        end
    endtask

    // One complete start -> sweep -> done transaction (or err response).
    task automatic run_sweep(input string nm, input int sd, input int ed, input int st,
                             input int rp, input logic exp_err, input int exp_busy);
        int n;
        bus.cfg_start_div = 8'(sd);
        bus.cfg_end_div   = 8'(ed);
        bus.cfg_step      = 8'(st);
        bus.cfg_reps      = 4'(rp);
        bus.cfg_loop      = 1'b0;
        bus.start         = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.cfg_start_div = 8'd77;   // must be ignored from here on
        if (exp_err) begin
            check({nm, ".err"}, {30'd0, bus.err, bus.busy}, 32'b10);
            tick();
            check({nm, ".err_1cyc"}, {30'd0, bus.err, bus.busy}, 32'b00);
            return;
        end
        build_model(sd, ed, st, rp);
        n = 0;
        while (bus.busy && n < 2000) begin
            check({nm, ".trace"}, {22'd0, obs()}, (n < mq.size()) ? {22'd0, mq[n]} : 32'd0);
            n++;
            tick();
        end
        check({nm, ".busy_len"}, n, (exp_busy < 0) ? mq.size() : exp_busy);
        check({nm, ".done"}, {21'd0, bus.done, bus.err, obs()}, {21'd0, 1'b1, 1'b0, 10'd0});
        bus.cfg_start_div = 8'(sd);
        bus.start = 1'b1;             // start during DONE is ignored
        tick();
        bus.start = 1'b0;
        check({nm, ".after_done"}, {21'd0, bus.done, bus.err, obs()}, 32'd0);
        tick();
        check({nm, ".stay_idle"}, {22'd0, obs()}, 32'd0);
    endtask

    initial begin
        tbl[0] = '{"basic",      8'd4,  8'd2, 8'd1, 4'd2, 1'b0, 36};
        tbl[1] = '{"saturate",   8'd10, 8'd3, 8'd4, 4'd1, 1'b0, 38};
        tbl[2] = '{"step0",      8'd5,  8'd2, 8'd0, 4'd1, 1'b1, 0};
        tbl[3] = '{"start_lt",   8'd2,  8'd5, 8'd1, 4'd1, 1'b1, 0};
        tbl[4] = '{"div1",       8'd1,  8'd1, 8'd1, 4'd3, 1'b0, 6};
        tbl[5] = '{"end0",       8'd3,  8'd0, 8'd1, 4'd1, 1'b1, 0};
        tbl[6] = '{"reps0",      8'd3,  8'd1, 8'd1, 4'd0, 1'b1, 0};
        tbl[7] = '{"single",     8'd5,  8'd5, 8'd2, 4'd2, 1'b0, 20};

        bus.start = 1'b0; bus.abort = 1'b0; bus.cfg_loop = 1'b0;
        bus.cfg_start_div = '0; bus.cfg_end_div = '0; bus.cfg_step = '0; bus.cfg_reps = '0;

        #12;
        check("reset_state", {19'd0, bus.done, bus.err, bus.busy, bus.out, bus.cur_div}, 32'd0);
        asyn_rst = 1'b0;
        tick();

        foreach (tbl[i])
            run_sweep(tbl[i].name, tbl[i].sd, tbl[i].ed, tbl[i].st, tbl[i].rp,
                      tbl[i].exp_err, tbl[i].exp_busy);

        // Start and abort together in IDLE: abort wins, no err.
        bus.cfg_start_div = 8'd4; bus.cfg_end_div = 8'd2; bus.cfg_step = 8'd1; bus.cfg_reps = 4'd1;
        bus.start = 1'b1; bus.abort = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort_idle", {30'd0, bus.err, bus.busy}, 32'd0);
        bus.cfg_step = 8'd0; bus.abort = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("start_abort_bad_cfg", {30'd0, bus.err, bus.busy}, 32'd0);

        // Looping sweep, ignored start/config mid-run, then abort mid-half-period.
        build_model(3, 1, 1, 1);
        bus.cfg_start_div = 8'd3; bus.cfg_end_div = 8'd1; bus.cfg_step = 8'd1;
        bus.cfg_reps = 4'd1; bus.cfg_loop = 1'b1; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c <= 25; c++) begin
            check("loop.trace", {21'd0, bus.done, obs()}, {21'd0, 1'b0, mq[c % mq.size()]});
            if (c == 15) begin
                bus.start = 1'b1; bus.cfg_start_div = 8'd8; bus.cfg_loop = 1'b0;
            end else begin
                bus.start = 1'b0;
            end
            if (c == 25) bus.abort = 1'b1;
            tick();
        end
        bus.abort = 1'b0;
        check("loop.abort", {21'd0, bus.done, obs()}, 32'd0);
        tick();
        check("loop.abort_idle", {20'd0, bus.done, bus.err, obs()}, 32'd0);

        // Asynchronous reset mid-sweep.
        bus.cfg_start_div = 8'd4; bus.cfg_end_div = 8'd2; bus.cfg_step = 8'd1;
        bus.cfg_reps = 4'd2; bus.cfg_loop = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (10) tick();
        check("pre_reset_busy", {31'd0, bus.busy}, 32'd1);
        #3 asyn_rst = 1'b1;
        #1;
        check("async_reset", {20'd0, bus.done, bus.err, obs()}, 32'd0);
        #29 asyn_rst = 1'b0;
        tick();
        check("post_reset_idle", {20'd0, bus.done, bus.err, obs()}, 32'd0);
        tick();
        check("post_reset_no_done", {31'd0, bus.done}, 32'd0);
        run_sweep("post_reset_sweep", 2, 1, 1, 1, 1'b0, 6);

        // Random configurations against the sweep model.
        for (int r = 0; r < 14; r++) begin
            int sd, ed, st, rp;
            sd = $urandom_range(1, 12);
            ed = $urandom_range(0, 12);
            st = $urandom_range(0, 5);
            rp = $urandom_range(0, 3);
            run_sweep("rand", sd, ed, st, rp, !model_valid(sd, ed, st, rp), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
